mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_if.sv | 43 ++++
 rtl/mem_req_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the three requester ports, the AXI-bridge side and the grant vector.
// slave = arbiter view, master = environment view (requesters plus bridge).
interface mem_req_arbiter_if;
    logic [63:0] icache_addr, icache_data, icache_rdata;
    logic [7:0]  icache_mask;
    logic        icache_we, icache_re, icache_finish;

    logic [63:0] dcache_addr, dcache_data, dcache_rdata;
    logic [7:0]  dcache_mask;
    logic        dcache_we, dcache_re, dcache_finish;

    logic [63:0] mmio_addr, mmio_data, mmio_rdata;
    logic [7:0]  mmio_mask;
    logic        mmio_we, mmio_re, mmio_finish;

    logic [63:0] axi_addr, axi_data, axi_rdata;
    logic [7:0]  axi_mask;
    logic        axi_we, axi_re, axi_finish;

    logic [2:0]  grant;

    modport slave (
        input  icache_addr, icache_data, icache_mask, icache_we, icache_re,
        input  dcache_addr, dcache_data, dcache_mask, dcache_we, dcache_re,
        input  mmio_addr, mmio_data, mmio_mask, mmio_we, mmio_re,
        input  axi_rdata, axi_finish,
        output icache_rdata, icache_finish, dcache_rdata, dcache_finish,
        output mmio_rdata, mmio_finish,
        output axi_addr, axi_data, axi_mask, axi_we, axi_re,
        output grant
    );

    modport master (
        output icache_addr, icache_data, icache_mask, icache_we, icache_re,
        output dcache_addr, dcache_data, dcache_mask, dcache_we, dcache_re,
        output mmio_addr, mmio_data, mmio_mask, mmio_we, mmio_re,
        output axi_rdata, axi_finish,
        input  icache_rdata, icache_finish, dcache_rdata, dcache_finish,
        input  mmio_rdata, mmio_finish,
        input  axi_addr, axi_data, axi_mask, axi_we, axi_re,
        input  grant
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Three-requester arbiter (icache, dcache, mmio) in front of a single AXI bridge.
// IDLE picks a winner, BUSY forwards until axi_finish, DONE is a one-cycle gap.
module mem_req_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_req_arbiter_if.slave         bus,
    output logic [1:0]               dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] last_q, last_d;
    logic [2:0] pend;
    logic [2:0] win;

    assign pend = {bus.mmio_we   | bus.mmio_re,
                   bus.dcache_we | bus.dcache_re,
                   bus.icache_we | bus.icache_re};

    // Round-robin search begins at the requester after last_q (one-hot).
    always_comb begin
        win = 3'b000;
        if (RR_EN != 0) begin
            case (last_q)
                3'b001: begin
                    if      (pend[1]) win = 3'b010;
                    else if (pend[2]) win = 3'b100;
                    else if (pend[0]) win = 3'b001;
                end
                3'b010: begin
                    if      (pend[2]) win = 3'b100;
                    else if (pend[0]) win = 3'b001;
                    else if (pend[1]) win = 3'b010;
                end
                default: begin
                    if      (pend[0]) win = 3'b001;
                    else if (pend[1]) win = 3'b010;
                    else if (pend[2]) win = 3'b100;
                end
            endcase
        end else begin
            if      (pend[2]) win = 3'b100;
            else if (pend[1]) win = 3'b010;
            else if (pend[0]) win = 3'b001;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    state_d = BUSY;
                    grant_d = win;
                    last_d  = win;
                end else begin
                    grant_d = 3'b000;
                end
            end
            BUSY: begin
                if (bus.axi_finish) begin
                    state_d = DONE;
                    grant_d = 3'b000;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            last_q  <= 3'b100;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Datapath is purely combinational from state_q/grant_q, so reset silences it at once.
    always_comb begin
        bus.axi_addr      = '0;
        bus.axi_data      = '0;
        bus.axi_mask      = '0;
        bus.axi_we        = 1'b0;
        bus.axi_re        = 1'b0;
        bus.icache_rdata  = '0;
        bus.icache_finish = 1'b0;
        bus.dcache_rdata  = '0;
        bus.dcache_finish = 1'b0;
        bus.mmio_rdata    = '0;
        bus.mmio_finish   = 1'b0;
        if (state_q == BUSY) begin
            if (grant_q[0]) begin
                bus.axi_addr      = bus.icache_addr;
                bus.axi_data      = bus.icache_data;
                bus.axi_mask      = bus.icache_mask;
                bus.axi_we        = bus.icache_we;
                bus.axi_re        = bus.icache_re;
                bus.icache_rdata  = bus.axi_rdata;
                bus.icache_finish = bus.axi_finish;
            end else if (grant_q[1]) begin
                bus.axi_addr      = bus.dcache_addr;
                bus.axi_data      = bus.dcache_data;
                bus.axi_mask      = bus.dcache_mask;
                bus.axi_we        = bus.dcache_we;
                bus.axi_re        = bus.dcache_re;
                bus.dcache_rdata  = bus.axi_rdata;
                bus.dcache_finish = bus.axi_finish;
            end else if (grant_q[2]) begin
                bus.axi_addr      = bus.mmio_addr;
                bus.axi_data      = bus.mmio_data;
                bus.axi_mask      = bus.mmio_mask;
                bus.axi_we        = bus.mmio_we;
                bus.axi_re        = bus.mmio_re;
                bus.mmio_rdata    = bus.axi_rdata;
                bus.mmio_finish   = bus.axi_finish;
            end
        end
    end

    assign bus.grant = grant_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench: round-robin DUT on bus, fixed-priority DUT on bus_fp.
// Handshake: a requester holds we/re until its finish pulse; the bridge pulses axi_finish for one cycle.
module tb_mem_req_arbiter;
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state, dbg_state_fp;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    mem_req_arbiter_if bus();
    mem_req_arbiter_if bus_fp();

    mem_req_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );
    mem_req_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus_fp), .dbg_state(dbg_state_fp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the next expected grant and compares it to the round-robin DUT.
    task automatic grant_check(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {61'd0, bus.grant}, e);
        end
    endtask

    task automatic clear_main();
        bus.icache_addr = '0; bus.icache_data = '0; bus.icache_mask = '0;
        bus.icache_we = 0; bus.icache_re = 0;
        bus.dcache_addr = '0; bus.dcache_data = '0; bus.dcache_mask = '0;
        bus.dcache_we = 0; bus.dcache_re = 0;
        bus.mmio_addr = '0; bus.mmio_data = '0; bus.mmio_mask = '0;
        bus.mmio_we = 0; bus.mmio_re = 0;
        bus.axi_rdata = '0; bus.axi_finish = 0;
    endtask

    task automatic clear_fp();
        bus_fp.icache_addr = '0; bus_fp.icache_data = '0; bus_fp.icache_mask = '0;
        bus_fp.icache_we = 0; bus_fp.icache_re = 0;
        bus_fp.dcache_addr = '0; bus_fp.dcache_data = '0; bus_fp.dcache_mask = '0;
        bus_fp.dcache_we = 0; bus_fp.dcache_re = 0;
        bus_fp.mmio_addr = '0; bus_fp.mmio_data = '0; bus_fp.mmio_mask = '0;
        bus_fp.mmio_we = 0; bus_fp.mmio_re = 0;
        bus_fp.axi_rdata = '0; bus_fp.axi_finish = 0;
    endtask

    // Pulses axi_finish on the main bus for one cycle; the state then is DONE.
    task automatic finish_main(input logic [63:0] rdata);
        bus.axi_rdata  = rdata;
        bus.axi_finish = 1'b1;
        #1;
        tick();
        bus.axi_finish = 1'b0;
        bus.axi_rdata  = '0;
        check("done_state", {62'd0, dbg_state}, {62'd0, S_DONE});
        check("done_grant", {61'd0, bus.grant}, 64'd0);
    endtask

    initial begin
        logic [63:0] ia, da, ma, rd;
        clear_main();
        clear_fp();

        // Reset state, including a request presented while reset is held
        tick(); tick();
        check("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
        check("rst_grant", {61'd0, bus.grant}, 64'd0);
        bus.dcache_re = 1'b1;
        tick();
        check("rst_hold_grant", {61'd0, bus.grant}, 64'd0);
        check("rst_axi_re", {63'd0, bus.axi_re}, 64'd0);
        bus.dcache_re = 1'b0;
        rst = 1'b0;

        // Single dcache read with 1-cycle grant latency
        bus.dcache_re = 1'b1;
        bus.dcache_addr = 64'h8000_0040;
        exp_q.push_back(64'b010);
        tick();
        grant_check("rd_grant");
        check("rd_axi_re", {63'd0, bus.axi_re}, 64'd1);
        check("rd_axi_addr", bus.axi_addr, 64'h8000_0040);
        bus.axi_rdata = 64'hDEAD_BEEF;
        bus.axi_finish = 1'b1;
        #1;
        check("rd_dfinish", {63'd0, bus.dcache_finish}, 64'd1);
        check("rd_drdata", bus.dcache_rdata, 64'hDEAD_BEEF);
        check("rd_ifinish", {63'd0, bus.icache_finish}, 64'd0);
        check("rd_irdata", bus.icache_rdata, 64'd0);
        tick();
        bus.axi_finish = 1'b0;
        bus.axi_rdata = '0;
        check("rd_grant_clear", {61'd0, bus.grant}, 64'd0);
        check("rd_axi_zero", {63'd0, bus.axi_re}, 64'd0);
        bus.dcache_re = 1'b0;
        tick();
        check("rd_back_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});

        // Hold and isolation: dcache drops re mid-BUSY
        bus.dcache_re = 1'b1;
        bus.dcache_addr = 64'h8000_1000;
        exp_q.push_back(64'b010);
        tick();
        grant_check("hold_grant");
        bus.dcache_re = 1'b0;
        for (int i = 0; i < $urandom_range(1, 4); i++) tick();
        check("hold_grant_kept", {61'd0, bus.grant}, 64'b010);
        check("hold_axi_addr", bus.axi_addr, 64'h8000_1000);
        check("hold_axi_re", {63'd0, bus.axi_re}, 64'd0);
        bus.axi_rdata = 64'h1234;
        bus.axi_finish = 1'b1;
        #1;
        check("iso_ifinish", {63'd0, bus.icache_finish}, 64'd0);
        check("iso_mfinish", {63'd0, bus.mmio_finish}, 64'd0);
        check("iso_mrdata", bus.mmio_rdata, 64'd0);
        check("iso_dfinish", {63'd0, bus.dcache_finish}, 64'd1);
        tick();
        // axi_finish left high through DONE and into IDLE must be ignored
        check("stray_done_dfinish", {63'd0, bus.dcache_finish}, 64'd0);
        tick();
        check("stray_idle_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
        check("stray_idle_dfinish", {63'd0, bus.dcache_finish}, 64'd0);
        tick();
        check("stray_idle_stay", {62'd0, dbg_state}, {62'd0, S_IDLE});
        check("stray_idle_grant", {61'd0, bus.grant}, 64'd0);
        bus.axi_finish = 1'b0;
        bus.axi_rdata = '0;

        // MMIO write mirrored until axi_finish
        bus.mmio_we = 1'b1;
        bus.mmio_addr = 64'hA000_03F8;
        bus.mmio_mask = 8'h01;
        bus.mmio_data = 64'h41;
        exp_q.push_back(64'b100);
        tick();
        grant_check("wr_grant");
        for (int i = 0; i < 2; i++) begin
            check("wr_axi_we", {63'd0, bus.axi_we}, 64'd1);
            check("wr_axi_addr", bus.axi_addr, 64'hA000_03F8);
            check("wr_axi_mask", {56'd0, bus.axi_mask}, 64'h01);
            check("wr_axi_data", bus.axi_data, 64'h41);
            tick();
        end
        finish_main(64'd0);
        bus.mmio_we = 1'b0;
        tick();

        // Round-robin with all three held pending through four transactions
        ia = {32'h1000_0000, $urandom()};
        da = {32'h2000_0000, $urandom()};
        ma = {32'h3000_0000, $urandom()};
        bus.icache_re = 1'b1; bus.icache_addr = ia;
        bus.dcache_re = 1'b1; bus.dcache_addr = da;
        bus.mmio_we = 1'b1;   bus.mmio_addr = ma;
        exp_q.push_back(64'b001);
        exp_q.push_back(64'b010);
        exp_q.push_back(64'b100);
        exp_q.push_back(64'b001);
        for (int t = 0; t < 4; t++) begin
            tick();
            grant_check("rr_grant");
            check("rr_axi_addr", bus.axi_addr, (t == 1) ? da : (t == 2) ? ma : ia);
            rd = 64'(t) + 64'h77;
            finish_main(rd);
            tick();
            check("rr_gap_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
        end
        clear_main();
        tick();

        // Fixed priority: mmio beats icache, icache follows after mmio_finish
        bus_fp.icache_re = 1'b1; bus_fp.icache_addr = 64'h111;
        bus_fp.mmio_re = 1'b1;   bus_fp.mmio_addr = 64'h333;
        tick();
        check("fp_first", {61'd0, bus_fp.grant}, 64'b100);
        check("fp_axi_addr", bus_fp.axi_addr, 64'h333);
        bus_fp.axi_finish = 1'b1;
        bus_fp.axi_rdata = 64'hAB;
        #1;
        check("fp_mfinish", {63'd0, bus_fp.mmio_finish}, 64'd1);
        check("fp_ifinish", {63'd0, bus_fp.icache_finish}, 64'd0);
        tick();
        bus_fp.axi_finish = 1'b0;
        bus_fp.mmio_re = 1'b0;
        tick();
        check("fp_gap_grant", {61'd0, bus_fp.grant}, 64'd0);
        tick();
        check("fp_second", {61'd0, bus_fp.grant}, 64'b001);
        bus_fp.axi_finish = 1'b1;
        #1;
        check("fp_irdata", bus_fp.icache_rdata, 64'hAB);
        tick();
        clear_fp();
        tick();

        // Reset mid-BUSY drops the transaction asynchronously
        bus.mmio_we = 1'b1;
        bus.mmio_addr = 64'hA000_0000;
        exp_q.push_back(64'b100);
        tick();
        grant_check("rb_grant");
        check("rb_axi_we", {63'd0, bus.axi_we}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rb_grant_async", {61'd0, bus.grant}, 64'd0);
        check("rb_axi_we_async", {63'd0, bus.axi_we}, 64'd0);
        check("rb_axi_re_async", {63'd0, bus.axi_re}, 64'd0);
        tick();
        bus.mmio_we = 1'b0;
        rst = 1'b0;
        bus.axi_finish = 1'b1;
        #1;
        check("rb_no_mfinish", {63'd0, bus.mmio_finish}, 64'd0);
        tick();
        check("rb_idle", {62'd0, dbg_state}, {62'd0, S_IDLE});
        check("rb_no_mfinish2", {63'd0, bus.mmio_finish}, 64'd0);
        bus.axi_finish = 1'b0;

        // Pointer restored to mmio by reset, so icache wins over dcache
        bus.icache_re = 1'b1; bus.icache_addr = 64'h5550;
        bus.dcache_re = 1'b1; bus.dcache_addr = 64'h6660;
        exp_q.push_back(64'b001);
        tick();
        grant_check("rb_ptr_grant");
        check("rb_ptr_addr", bus.axi_addr, 64'h5550);
        finish_main(64'd0);
        clear_main();
        tick();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
